// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch port
// (IF) and the load/store port (DM). Each cycle at most one requester is
// granted and drives the memory port. Read data returns one cycle later and is
// steered to whichever port owned the read. DM normally wins contention; a
// streak counter hands the port to IF after STARVE_LIMIT consecutive DM grants
// taken while IF was waiting.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   if_req_i/if_addr_i           fetch read request and address
//   if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant, read valid, read data
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request, write flag, addr, data
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o  data grant, read valid, read data
//   stall_if_o                   fetch must hold PC/IF register
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory port
//   mem_rdata_i                  memory read data, 1 cycle after a read enable
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  stall_if_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] ONE_C   = SW'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    owner_e        resp_owner_q, resp_owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          if_gnt_s, dm_gnt_s;

    // State register: response owner and starvation streak
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_owner_q <= OWN_NONE;
            streak_q     <= '0;
        end else begin
            resp_owner_q <= resp_owner_d;
            streak_q     <= streak_d;
        end
    end

    // Grant decision: DM wins contention unless IF has waited STARVE_LIMIT grants
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (reset) begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end else if (if_req_i && dm_req_i) begin
            if (streak_q == LIMIT_C) begin
                if_gnt_s = 1'b1;
            end else begin
                dm_gnt_s = 1'b1;
            end
        end else begin
            if_gnt_s = if_req_i;
            dm_gnt_s = dm_req_i;
        end
    end

    // Next-state: streak saturates at the limit; owner tracks the read in flight
    always_comb begin
        streak_d     = streak_q;
        resp_owner_d = OWN_NONE;
        if (if_gnt_s || !if_req_i) begin
            streak_d = '0;
        end else if (dm_gnt_s && (streak_q != LIMIT_C)) begin
            streak_d = streak_q + ONE_C;
        end else begin
            streak_d = streak_q;
        end
        if (if_gnt_s) begin
            resp_owner_d = OWN_IF;
        end else if (dm_gnt_s && !dm_we_i) begin
            resp_owner_d = OWN_DM;
        end else begin
            resp_owner_d = OWN_NONE;
        end
    end

    // Memory port mux: granted port drives the bus, idle bus is all zeros
    always_comb begin
        mem_en_o    = if_gnt_s | dm_gnt_s;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt_s) begin
            mem_addr_o = if_addr_i;
        end else if (dm_gnt_s) begin
            mem_we_o    = dm_we_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
        end else begin
            mem_we_o = 1'b0;
        end
    end

    // Response routing; reset suppresses a response still in flight
    always_comb begin
        if_rvalid_o = (resp_owner_q == OWN_IF) && !reset;
        dm_rvalid_o = (resp_owner_q == OWN_DM) && !reset;
        if_rdata_o  = '0;
        dm_rdata_o  = '0;
        if (if_rvalid_o) begin
            if_rdata_o = mem_rdata_i;
        end else begin
            if_rdata_o = '0;
        end
        if (dm_rvalid_o) begin
            dm_rdata_o = mem_rdata_i;
        end else begin
            dm_rdata_o = '0;
        end
    end

    assign if_gnt_o   = if_gnt_s;
    assign dm_gnt_o   = dm_gnt_s;
    assign stall_if_o = if_req_i & ~if_gnt_s & ~reset;

endmodule
